// File: rtl/operand_fetch_pkg.sv
// Opcode map and instruction classification shared by operand fetch and write-back.
// Select encodings follow the write-back datapath's select field.
package operand_fetch_pkg;

  localparam int unsigned NREGS = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned IDX_W = $clog2(NREGS);
  localparam int unsigned SEL_W = 6;

  localparam logic [SEL_W-1:0] OP_LOAD = 6'b000010;
  localparam logic [SEL_W-1:0] OP_ADD  = 6'b000100;
  localparam logic [SEL_W-1:0] OP_SUB  = 6'b000101;
  localparam logic [SEL_W-1:0] OP_NEG  = 6'b000110;
  localparam logic [SEL_W-1:0] OP_MUL  = 6'b000111;
  localparam logic [SEL_W-1:0] OP_NOT  = 6'b001110;
  localparam logic [SEL_W-1:0] OP_LRSH = 6'b010000;

  typedef enum logic [1:0] {
    CLS_ILLEGAL,
    CLS_UNARY,
    CLS_BINARY,
    CLS_WIDE
  } op_class_t;

  function automatic logic is_supported(input logic [SEL_W-1:0] sel);
    return (sel >= OP_ADD) && (sel <= OP_LRSH);
  endfunction

  function automatic logic is_unary(input logic [SEL_W-1:0] sel);
    return (sel == OP_NEG) || (sel == OP_NOT);
  endfunction

  function automatic logic is_wide(input logic [SEL_W-1:0] sel);
    return sel == OP_MUL;
  endfunction

  function automatic op_class_t op_class(input logic [SEL_W-1:0] sel);
    if (!is_supported(sel)) return CLS_ILLEGAL;
    if (is_wide(sel))       return CLS_WIDE;
    if (is_unary(sel))      return CLS_UNARY;
    return CLS_BINARY;
  endfunction

endpackage

// File: rtl/operand_fetch_regfile.sv
// Register file: two asynchronous read ports, one write port that can update
// a register pair (wide results spill into the next index, wrapping at the top).
module regfile_2r1w #(
  parameter  int unsigned NREGS = 16,
  parameter  int unsigned DW    = 16,
  localparam int unsigned IW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   i_ra1,
  input  logic [IW-1:0]   i_ra2,
  output logic [DW-1:0]   o_rd1,
  output logic [DW-1:0]   o_rd2,
  input  logic            i_we,
  input  logic            i_wide,
  input  logic [IW-1:0]   i_waddr,
  input  logic [2*DW-1:0] i_wdata
);

  logic [DW-1:0] r_mem [NREGS];
  logic [IW-1:0] w_waddr_hi;

  assign w_waddr_hi = i_waddr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata[DW-1:0];
      if (i_wide) r_mem[w_waddr_hi] <= i_wdata[2*DW-1:DW];
    end
  end

  assign o_rd1 = r_mem[i_ra1];
  assign o_rd2 = r_mem[i_ra2];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: holds a decoded instruction until its operands and destinations
// are free of pending writes, then issues operands to the ALU with 1-cycle latency.
module operand_fetch #(
  parameter  int unsigned NREGS = 16,
  parameter  int unsigned DW    = 16,
  localparam int unsigned IW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_select,
  input  logic [IW-1:0]   in_rd,
  input  logic [IW-1:0]   in_rs1,
  input  logic [IW-1:0]   in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_select,
  output logic [IW-1:0]   out_rd,
  output logic [DW-1:0]   out_a,
  output logic [DW-1:0]   out_b,
  input  logic            wb_en,
  input  logic            wb_wide,
  input  logic [IW-1:0]   wb_rd,
  input  logic [2*DW-1:0] wb_data,
  output logic            illegal_op
);

  import operand_fetch_pkg::*;

  logic [NREGS-1:0] r_busy;
  logic             r_out_valid;
  logic [5:0]       r_out_select;
  logic [IW-1:0]    r_out_rd;
  logic [DW-1:0]    r_out_a;
  logic [DW-1:0]    r_out_b;
  logic             r_illegal;

  op_class_t        w_cls;
  logic             w_supported;
  logic             w_unary;
  logic             w_wide;
  logic [IW-1:0]    w_rd_hi;
  logic [IW-1:0]    w_wb_rd_hi;
  logic             w_rs1_lo_hit;
  logic             w_rs1_hi_hit;
  logic             w_rs2_lo_hit;
  logic             w_rs2_hi_hit;
  logic             w_rs1_haz;
  logic             w_rs2_haz;
  logic             w_waw;
  logic             w_hazard;
  logic             w_slot_free;
  logic             w_accept;
  logic             w_issue;
  logic [DW-1:0]    w_rf_rd1;
  logic [DW-1:0]    w_rf_rd2;
  logic [DW-1:0]    w_op_a;
  logic [DW-1:0]    w_op_b;
  logic [NREGS-1:0] w_busy_set;
  logic [NREGS-1:0] w_busy_clr;

  regfile_2r1w #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .i_ra1   (in_rs1),
    .i_ra2   (in_rs2),
    .o_rd1   (w_rf_rd1),
    .o_rd2   (w_rf_rd2),
    .i_we    (wb_en),
    .i_wide  (wb_wide),
    .i_waddr (wb_rd),
    .i_wdata (wb_data)
  );

  assign w_cls       = op_class(in_select);
  assign w_supported = (w_cls != CLS_ILLEGAL);
  assign w_unary     = (w_cls == CLS_UNARY);
  assign w_wide      = (w_cls == CLS_WIDE);
  assign w_rd_hi     = in_rd + 1'b1;
  assign w_wb_rd_hi  = wb_rd + 1'b1;

  assign w_rs1_lo_hit = wb_en && (wb_rd == in_rs1);
  assign w_rs1_hi_hit = wb_en && wb_wide && (w_wb_rd_hi == in_rs1);
  assign w_rs2_lo_hit = wb_en && (wb_rd == in_rs2);
  assign w_rs2_hi_hit = wb_en && wb_wide && (w_wb_rd_hi == in_rs2);

  // A source being written back this cycle is forwarded, so it never stalls;
  // destinations get no such relief because the reservation must be fresh.
  assign w_rs1_haz = r_busy[in_rs1] && !(w_rs1_lo_hit || w_rs1_hi_hit);
  assign w_rs2_haz = !w_unary && r_busy[in_rs2] && !(w_rs2_lo_hit || w_rs2_hi_hit);
  assign w_waw     = r_busy[in_rd] || (w_wide && r_busy[w_rd_hi]);
  assign w_hazard  = w_supported && (w_rs1_haz || w_rs2_haz || w_waw);

  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = !rst && w_slot_free && !w_hazard;
  assign w_accept    = in_valid && in_ready;
  assign w_issue     = w_accept && w_supported;

  always_comb begin
    w_op_a = w_rf_rd1;
    if (w_rs1_lo_hit)      w_op_a = wb_data[DW-1:0];
    else if (w_rs1_hi_hit) w_op_a = wb_data[2*DW-1:DW];

    w_op_b = w_rf_rd2;
    if (w_unary)           w_op_b = '0;
    else if (w_rs2_lo_hit) w_op_b = wb_data[DW-1:0];
    else if (w_rs2_hi_hit) w_op_b = wb_data[2*DW-1:DW];
  end

  always_comb begin
    w_busy_clr = '0;
    w_busy_set = '0;
    if (wb_en) begin
      w_busy_clr[wb_rd] = 1'b1;
      if (wb_wide) w_busy_clr[w_wb_rd_hi] = 1'b1;
    end
    if (w_issue) begin
      w_busy_set[in_rd] = 1'b1;
      if (w_wide) w_busy_set[w_rd_hi] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy       <= '0;
      r_out_valid  <= 1'b0;
      r_out_select <= '0;
      r_out_rd     <= '0;
      r_out_a      <= '0;
      r_out_b      <= '0;
      r_illegal    <= 1'b0;
    end else begin
      r_busy    <= (r_busy & ~w_busy_clr) | w_busy_set;
      r_illegal <= w_accept && !w_supported;
      if (w_issue) begin
        r_out_valid  <= 1'b1;
        r_out_select <= in_select;
        r_out_rd     <= in_rd;
        r_out_a      <= w_op_a;
        r_out_b      <= w_op_b;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_select = r_out_select;
  assign out_rd     = r_out_rd;
  assign out_a      = r_out_a;
  assign out_b      = r_out_b;
  assign illegal_op = r_illegal;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side counterpart of the write-back stage. It accepts decoded ALU instructions and reads a 16x16 register file.
- It holds each instruction until its source operands are free of pending writes, then issues operands and the 6-bit select to the ALU/write-back path.
- The write-back result port terminates here: results update the register file and clear the pending-write scoreboard.

Parameters:
NREGS, 16, number of architectural registers (power of two; index width = log2(NREGS))
DW, 16, register data width

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
in_select  in  6  opcode (write-back select encoding)
in_rd  in  4  destination register
in_rs1  in  4  source 1
in_rs2  in  4  source 2
out_valid  out  1  operands valid to ALU
out_ready  in  1  ALU consumes when out_valid && out_ready
out_select  out  6  registered opcode
out_rd  out  4  registered destination
out_a  out  16  operand A
out_b  out  16  operand B (0 for unary ops)
wb_en  in  1  write-back strobe
wb_wide  in  1  32-bit result (MUL): low half to wb_rd, high half to wb_rd+1 mod NREGS
wb_rd  in  4  write-back destination
wb_data  in  32  write-back data (only [15:0] used unless wb_wide)
illegal_op  out  1  one-cycle pulse when an unsupported opcode is accepted

Behaviour:
- Reset (rst=1 at clk edge):
  - all registers, busy bits, out_valid, out_select, out_rd, out_a, out_b and illegal_op go to 0.
  - Reset mid-stall discards the held instruction; in_ready is driven 0 during the reset cycle.
- Supported opcodes are 000100 ADD through 010000 LRSH.
  - Unary: 000110 NEG and 001110 NOT use rs1 only; rs2 is not hazard-checked and out_b=0.
  - All others are binary.
  - Wide: 000111 MUL reserves rd and rd+1 mod NREGS.
- Any other opcode (MOV/LOAD/STORE/undefined):
  - accepted without a hazard check and dropped; no output and no scoreboard change.
  - illegal_op pulses the next cycle.
- Scoreboard: one busy bit per register.
  - Set on issue for rd (and rd+1 if MUL).
  - Cleared on wb_en for wb_rd (and wb_rd+1 if wb_wide).
  - If a set and a clear hit the same bit in one cycle, the set wins.
- Hazard stall: a supported instruction stalls (in_ready=0) if rs1 is busy, rs2 is busy (binary only), or any reserved destination is busy (WAW).
  - Exception: a source that wb writes in the same cycle is not a hazard; it is bypassed from wb_data (low or high half as indexed).
- Flow:
  - in_ready = !rst && (!out_valid || out_ready) && !hazard.
  - Accept registers the operands and asserts out_valid at the next edge (1-cycle latency).
  - out_* hold stable while out_valid && !out_ready.
  - Back-to-back: accept and consume in the same cycle gives throughput of 1 per cycle.
- Register file write:
  - A wb write lands at the edge, so a read in the same cycle sees the bypassed value.
  - A wide write with wb_rd=15 writes the high half to r0 (wrap).
- out_valid drops after consume if nothing is accepted that cycle.

Decomposition:
- Shared package (also used by write-back): opcode localparams OP_ADD..OP_LRSH, is_unary/is_wide/is_supported functions, DW and register-index width.
- One sub-module, regfile_2r1w (two async read ports, one write port of up to two registers, no reset on read path), plus scoreboard logic in the top.

Test Plan:
1. Reset, then write r1=0x0003 and r2=0x0005 via wb; issue ADD rd=3 rs1=1 rs2=2 -> next cycle out_valid=1, out_a=0x0003, out_b=0x0005, out_select=000100, busy[3]=1.
2. Issue ADD rd=3, then SUB rd=4 rs1=3 rs2=1 -> SUB stalls (in_ready=0) until wb_en rd=3 data=0x0008; in that cycle it is accepted with bypassed out_a=0x0008.
3. MUL rd=15; wb_wide=1 wb_rd=15 wb_data=0x12345678 -> r15=0x5678, r0=0x1234; busy[15] and busy[0] cleared; a following read of r0 returns 0x1234.
4. Hold out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0; release -> next instruction is issued the following cycle.
5. Accept in_select=000010 (LOAD) -> illegal_op=1 for exactly one cycle, out_valid stays 0, scoreboard unchanged.
6. Assert rst while an instruction is stalled on busy[5] -> all outputs and busy bits 0 next cycle; the re-presented instruction is accepted immediately.
